// File: rtl/game_pkg.sv
// Shared types and constants for the pixel compositor: fade state encoding,
// brightness and chroma-key constants, and the packed RGB pixel type.
package game_pkg;

  typedef enum logic [1:0] {
    FS_IDLE     = 2'd0,
    FS_FADE_OUT = 2'd1,
    FS_SWAP     = 2'd2,
    FS_FADE_IN  = 2'd3
  } fade_state_t;

  localparam logic [4:0]  FULL_BRIGHT = 5'd16;
  localparam logic [23:0] CHROMA_KEY  = 24'hFF00FF;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/pixel_compositor_fade_scaler.sv
// One colour channel scaled by the current fade brightness: (c * bright) >> STEP_SHIFT.
module fade_scaler #(
  parameter int DATA_W     = 8,
  parameter int COEF_W     = 5,
  parameter int STEP_SHIFT = 4
) (
  input  logic [DATA_W-1:0] c,
  input  logic [COEF_W-1:0] bright,
  output logic [DATA_W-1:0] out
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic [PROD_W-1:0] prod;

  assign prod = PROD_W'(c) * PROD_W'(bright);
  // bright never exceeds full scale, so the shifted product always fits DATA_W
  assign out  = DATA_W'(prod >> STEP_SHIFT);

endmodule

// File: rtl/pixel_compositor.sv
// Final colour stage before the VGA DAC: sprite priority merge, level-change fade, sync alignment.
// Optional build macro PIXEL_COMPOSITOR_CHROMA_KEY_EN makes magenta sprite pixels transparent.
module pixel_compositor
  import game_pkg::*;
#(
  parameter int BG_LATENCY      = 1,
  parameter int FRAMES_PER_STEP = 2,
  parameter int STEP_SHIFT      = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_n_in,
  input  logic [23:0] data_Out_background,
  input  logic [23:0] tower_rgb,
  input  logic [23:0] enemy_rgb,
  input  logic [23:0] ui_rgb,
  input  logic        tower_vld,
  input  logic        enemy_vld,
  input  logic        ui_vld,
  input  logic [2:0]  level_req,
  output logic [2:0]  level_index,
  output logic        fade_busy,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N
);

  localparam int DLY   = BG_LATENCY + 2;
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  function automatic logic [4:0] bright_dec(input logic [4:0] b);
    return (b == 5'd0) ? 5'd0 : b - 5'd1;
  endfunction

  function automatic logic [4:0] bright_inc(input logic [4:0] b);
    return (b >= FULL_BRIGHT) ? FULL_BRIGHT : b + 5'd1;
  endfunction

  fade_state_t       state_q, state_d;
  logic [4:0]        bright_q, bright_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        target_q, target_d;
  logic [2:0]        level_q, level_d;
  logic [DLY-1:0]    hs_sr_q, hs_sr_d;
  logic [DLY-1:0]    vs_sr_q, vs_sr_d;
  logic [DLY-1:0]    blank_sr_q, blank_sr_d;
  rgb_t              pix_p0_q, pix_p0_d;
  rgb_t              col_p1_q, col_p1_d;
  rgb_t              scaled;
  logic              tower_on, enemy_on, ui_on;

`ifdef PIXEL_COMPOSITOR_CHROMA_KEY_EN
  assign tower_on = tower_vld && (tower_rgb != CHROMA_KEY);
  assign enemy_on = enemy_vld && (enemy_rgb != CHROMA_KEY);
  assign ui_on    = ui_vld    && (ui_rgb    != CHROMA_KEY);
`else
  assign tower_on = tower_vld;
  assign enemy_on = enemy_vld;
  assign ui_on    = ui_vld;
`endif

  // Stage p0: layer priority select
  always_comb begin
    pix_p0_d = rgb_t'(data_Out_background);
    if (ui_on)         pix_p0_d = rgb_t'(ui_rgb);
    else if (enemy_on) pix_p0_d = rgb_t'(enemy_rgb);
    else if (tower_on) pix_p0_d = rgb_t'(tower_rgb);
  end

  // Stage p1: fade scaling and blank masking, registered straight onto the pins
  fade_scaler #(.DATA_W(8), .COEF_W(5), .STEP_SHIFT(STEP_SHIFT)) u_scale_r (
    .c(pix_p0_q.r), .bright(bright_q), .out(scaled.r));
  fade_scaler #(.DATA_W(8), .COEF_W(5), .STEP_SHIFT(STEP_SHIFT)) u_scale_g (
    .c(pix_p0_q.g), .bright(bright_q), .out(scaled.g));
  fade_scaler #(.DATA_W(8), .COEF_W(5), .STEP_SHIFT(STEP_SHIFT)) u_scale_b (
    .c(pix_p0_q.b), .bright(bright_q), .out(scaled.b));

  always_comb begin
    col_p1_d   = blank_sr_q[BG_LATENCY] ? scaled : '0;
    hs_sr_d    = {hs_sr_q[DLY-2:0], hs_in};
    vs_sr_d    = {vs_sr_q[DLY-2:0], vs_in};
    blank_sr_d = {blank_sr_q[DLY-2:0], blank_n_in};
  end

  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    level_d  = level_q;
    if (frame_start) begin
      case (state_q)
        FS_IDLE: begin
          cnt_d = '0;
          if (level_req != level_q) begin
            target_d = level_req;
            state_d  = FS_FADE_OUT;
          end
        end
        FS_FADE_OUT: begin
          // target follows level_req until black, so late requests are honoured without restarting
          target_d = level_req;
          if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            bright_d = bright_dec(bright_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bright_d == 5'd0) begin
            level_d = target_d;
            state_d = FS_SWAP;
            cnt_d   = '0;
          end
        end
        FS_SWAP: begin
          state_d = FS_FADE_IN;
          cnt_d   = '0;
        end
        default: begin
          if (level_req != level_q) begin
            target_d = level_req;
            state_d  = FS_FADE_OUT;
            cnt_d    = '0;
          end else begin
            if (cnt_q == CNT_LAST) begin
              cnt_d    = '0;
              bright_d = bright_inc(bright_q);
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (bright_d == FULL_BRIGHT) begin
              state_d = FS_IDLE;
              cnt_d   = '0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= FS_IDLE;
      bright_q   <= FULL_BRIGHT;
      cnt_q      <= '0;
      target_q   <= '0;
      level_q    <= '0;
      hs_sr_q    <= '1;
      vs_sr_q    <= '1;
      blank_sr_q <= '0;
      col_p1_q   <= '0;
    end else begin
      state_q    <= state_d;
      bright_q   <= bright_d;
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      level_q    <= level_d;
      hs_sr_q    <= hs_sr_d;
      vs_sr_q    <= vs_sr_d;
      blank_sr_q <= blank_sr_d;
      col_p1_q   <= col_p1_d;
    end
  end

  always_ff @(posedge Clk) begin
    pix_p0_q <= pix_p0_d;
  end

  assign VGA_R       = col_p1_q.r;
  assign VGA_G       = col_p1_q.g;
  assign VGA_B       = col_p1_q.b;
  assign VGA_HS      = hs_sr_q[DLY-1];
  assign VGA_VS      = vs_sr_q[DLY-1];
  assign VGA_BLANK_N = blank_sr_q[DLY-1];
  assign level_index = level_q;
  assign fade_busy   = (state_q != FS_IDLE);

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Sits directly downstream of the background stage and directly upstream of the VGA DAC pins.
- Merges the registered background colour with three sprite layers by fixed priority.
- Applies a frame-synchronous fade-to-black/fade-in when the game level changes, and drives the displayed level back to the background stage.
- Delays the sync and blank strobes so they stay pixel-aligned with the colour pipeline.

Parameters:
- BG_LATENCY, 1, cycles from DrawX/DrawY to valid background/sprite data
- FRAMES_PER_STEP, 2, frames held at each brightness step during a fade
- STEP_SHIFT, 4, log2 of the full-brightness value (full = 16)

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- hs_in, vs_in  in  1 each  raw syncs from the timing generator, active-low
- blank_n_in  in  1  raw blank, 1 = visible
- data_Out_background  in  24  background RGB, BG_LATENCY after DrawX/DrawY
- tower_rgb, enemy_rgb, ui_rgb  in  24 each  sprite layer colours, same latency as background
- tower_vld, enemy_vld, ui_vld  in  1 each  sprite layer pixel present
- level_req  in  3  requested level from game FSM
- level_index  out  3  level currently displayed; feeds the background stage
- fade_busy  out  1  high while a fade is in progress
- VGA_R, VGA_G, VGA_B  out  8 each  final colour
- VGA_HS, VGA_VS, VGA_BLANK_N  out  1 each  aligned syncs and blank

Behaviour:
- Reset values: VGA_R/G/B=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, level_index=0, fade_busy=0, bright=16, state=IDLE, frame counter=0.
- Stage A (registered):
  - Priority select: ui > enemy > tower > background.
  - A layer wins only when its vld is 1.
- Stage B (registered):
  - Fade scaling per channel: out = (c * bright) >> STEP_SHIFT.
  - c is 8 bits and bright is 5 bits (0..16), so the product is 13 bits.
  - bright=16 must reproduce c exactly; bright=0 gives 0.
- Output colour is forced to 0 whenever the aligned blank_n is 0.
- Latency:
  - Colour: DrawX to VGA pins = BG_LATENCY+2 cycles.
  - Syncs: hs_in, vs_in and blank_n_in go through a shift register of depth BG_LATENCY+2, so all outputs are aligned.
- Fade FSM: states IDLE, FADE_OUT, SWAP, FADE_IN. All transitions are evaluated only on frame_start.
  - IDLE: if level_req != level_index, latch target <= level_req and go to FADE_OUT; fade_busy=1.
  - FADE_OUT: every FRAMES_PER_STEP frame_starts, bright -= 1. At bright==0, go to SWAP.
  - SWAP: level_index <= target, then go to FADE_IN on the next frame_start. The background therefore switches while the screen is black.
  - FADE_IN: bright += 1 per step. At bright==16, go to IDLE and fade_busy=0.
- Frame counter: counts 0..FRAMES_PER_STEP-1, resets on each step, and is held at 0 in IDLE.
- Boundary cases:
  - level_req changes during FADE_OUT: target is updated and the fade continues; no restart.
  - level_req changes during FADE_IN to a value != level_index: go back to FADE_OUT from the current bright, with no jump.
  - level_req returns to level_index during FADE_OUT: the fade still completes a full out/in cycle.
  - frame_start asserted while Reset is high: ignored.
  - Reset mid-fade: immediate return to reset values, with full brightness on the next visible pixel.
- bright never underflows below 0 or exceeds 16 (saturating).

Optional Feature:
- Macro: PIXEL_COMPOSITOR_CHROMA_KEY_EN.
- Defined: a sprite layer also counts as transparent when its rgb == 24'hFF00FF, even with vld=1.
- Undefined: only vld governs transparency, and magenta is displayed literally.

Decomposition:
- Shared package game_pkg holds:
  - the fade_state_t enum
  - the constants FULL_BRIGHT=16 and CHROMA_KEY=24'hFF00FF
  - a typedef rgb_t as a 24-bit packed struct of r, g, b
- One natural sub-module, fade_scaler: a per-channel 8x5 multiply-shift used three times.
- The FSM and the delay line stay in the top module.

Test Plan:
- Priority: background 24'h808080 with tower_vld=1 (tower_rgb=24'h112233) and ui_vld=1 (ui_rgb=24'hABCDEF) -> VGA outputs AB/CD/EF exactly 3 cycles later; with only tower_vld -> 11/22/33.
- Alignment: pulse hs_in low for 96 cycles -> VGA_HS low for 96 cycles, delayed by 3; blank_n_in=0 with ui_vld=1 -> RGB=0.
- Fade: level_req 0->1 with FRAMES_PER_STEP=2 -> fade_busy rises at the next frame_start. Background 24'hC0C0C0 reads C0 at bright 16 and 60 at bright 8. level_index becomes 1 after 32 frames, bright returns to 16 after 32 more, then fade_busy=0.
- Retarget: level_req changes to 2 mid-FADE_IN at bright=10 -> bright steps down to 9, reaches 0, then level_index=2.
- Reset mid-fade: assert Reset at bright=5 -> level_index=0, bright=16, outputs at reset values asynchronously, before the next clock edge.
- Chroma key (macro defined): enemy_vld=1 with enemy_rgb=24'hFF00FF over tower 24'h010203 -> output 01/02/03; with the macro undefined -> FF/00/FF.
